// File: rtl/interrupt_request_register.sv
// Interrupt request register: synchronizes IR lines, latches edge/level
// requests into IRR, freezes updates during acknowledge, and applies
// acknowledge and ICW1 clears.
// Optional build macro: IRR_GLITCH_FILTER_EN adds a per-line filter register
// that rejects single-clock pulses at the cost of one extra clock of latency.
`timescale 1ns/1ps

module interrupt_request_register #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IR,
  input  logic       LTIM,
  input  logic       ICW1Write,
  input  logic       INTA,
  input  logic       clearFlag,
  input  logic [2:0] clearBit,
  output logic [7:0] IRR,
  output logic       IRRFrozen
);

  localparam int unsigned IR_W = 8;

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0][IR_W-1:0] r_sync;
  logic [IR_W-1:0]                  w_s;
  logic [IR_W-1:0]                  r_arm;
  logic [IR_W-1:0]                  r_irr;
  logic                             r_frozen;
  logic [IR_W-1:0]                  w_irr_nxt;
  logic [IR_W-1:0]                  w_arm_nxt;

  // Multi-stage synchronizer; stage 0 samples the raw lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], IR};
    end
  end

`ifdef IRR_GLITCH_FILTER_EN
  logic [IR_W-1:0] r_filt;
  logic [IR_W-1:0] w_sync_eq;

  // Two consecutive synchronizer samples must agree before S follows them
  assign w_sync_eq = ~(r_sync[SYNC_STAGES-1] ^ r_sync[SYNC_STAGES-2]);

  // Glitch filter register: holds its value until the synchronizer settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
    end else begin
      r_filt <= (r_filt & ~w_sync_eq) | (r_sync[SYNC_STAGES-1] & w_sync_eq);
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = r_sync[SYNC_STAGES-1];
`endif

  // Freeze follows the sampled acknowledge, one clock late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frozen <= 1'b0;
    end else begin
      r_frozen <= ~INTA;
    end
  end

  // Next-state for request and arm bits; ICW1 beats clear beats set
  always_comb begin
    w_irr_nxt = r_irr;
    w_arm_nxt = r_arm;
    for (int i = 0; i < int'(IR_W); i++) begin
      // Arm tracks a low synced line even while frozen
      if (!w_s[i]) begin
        w_arm_nxt[i] = 1'b1;
      end
      if (!r_frozen) begin
        if (LTIM) begin
          w_irr_nxt[i] = w_s[i];
        end else if (w_s[i] && r_arm[i]) begin
          w_irr_nxt[i] = 1'b1;
          w_arm_nxt[i] = 1'b0;
        end
      end
    end
    if (clearFlag) begin
      w_irr_nxt[clearBit] = 1'b0;
    end
    if (ICW1Write) begin
      w_irr_nxt = '0;
      w_arm_nxt = '0;
    end
  end

  // Request and arm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irr <= '0;
      r_arm <= '0;
    end else begin
      r_irr <= w_irr_nxt;
      r_arm <= w_arm_nxt;
    end
  end

  assign IRR       = r_irr;
  assign IRRFrozen = r_frozen;

endmodule

// File: tb/tb_interrupt_request_register.sv
// Scoreboard bench for interrupt_request_register: stimulus queues expected
// IRR/IRRFrozen values tagged with the clock edge they must appear after;
// a monitor compares them just after each rising edge.
`timescale 1ns/1ps

module tb_interrupt_request_register;

  localparam int unsigned SYNC_STAGES = 2;
`ifdef IRR_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 2;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] irr;
    logic       frz;
    bit         chk_frz;
    string      nm;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] IR;
  logic       LTIM;
  logic       ICW1Write;
  logic       INTA;
  logic       clearFlag;
  logic [2:0] clearBit;
  logic [7:0] IRR;
  logic       IRRFrozen;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  interrupt_request_register #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR        (IR),
    .LTIM      (LTIM),
    .ICW1Write (ICW1Write),
    .INTA      (INTA),
    .clearFlag (clearFlag),
    .clearBit  (clearBit),
    .IRR       (IRR),
    .IRRFrozen (IRRFrozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect values after rising edge (current count + k)
  task automatic exp_push(input int k, input logic [7:0] irr, input logic frz,
                          input bit chk_frz, input string nm);
    exp_t e;
    e.cyc = cyc + k;
    e.irr = irr;
    e.frz = frz;
    e.chk_frz = chk_frz;
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at this edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if ((IRR !== sb[i].irr) || (sb[i].chk_frz && (IRRFrozen !== sb[i].frz))) begin
            errors++;
            $display("FAIL %s edge=%0d: IRR=%h IRRFrozen=%b, expected IRR=%h IRRFrozen=%b%s",
                     sb[i].nm, cyc, IRR, IRRFrozen, sb[i].irr, sb[i].frz,
                     sb[i].chk_frz ? "" : " (frozen not checked)");
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for edge %0d was skipped", sb[i].nm, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, got time=%0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; IR = 8'h00; LTIM = 1'b0; ICW1Write = 1'b0;
    INTA = 1'b1; clearFlag = 1'b0; clearBit = 3'd0;

    // Reset state
    tick(1);
    exp_push(1, 8'h00, 1'b0, 1'b1, "reset_hold");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Edge mode: latency, acknowledge clear, no re-set while held high
    IR = 8'h04;
    exp_push(LAT - 1, 8'h00, 1'b0, 1'b1, "edge_before_latency");
    exp_push(LAT,     8'h04, 1'b0, 1'b1, "edge_latency");
    tick(LAT + 1);
    clearFlag = 1'b1; clearBit = 3'd2;
    exp_push(1, 8'h00, 1'b0, 1'b1, "edge_ack_clear");
    exp_push(4, 8'h00, 1'b0, 1'b1, "edge_held_no_reset");
    tick(1);
    clearFlag = 1'b0;
    tick(4);
    IR = 8'h00;
    tick(3);
    IR = 8'h04;
    exp_push(LAT - 1, 8'h00, 1'b0, 1'b1, "edge_rearm_before");
    exp_push(LAT,     8'h04, 1'b0, 1'b1, "edge_rearm_set");
    tick(LAT + 1);
    IR = 8'h00;
    tick(3);
    clearFlag = 1'b1; clearBit = 3'd2;
    exp_push(1, 8'h00, 1'b0, 1'b1, "edge_cleanup");
    tick(1);
    clearFlag = 1'b0;
    tick(2);

    // Level mode: 10-cycle pulse follows with latency, then drops
    LTIM = 1'b1;
    tick(1);
    exp_push(LAT - 1, 8'h00, 1'b0, 1'b0, "level_before");
    for (int k = LAT; k < LAT + 10; k++) exp_push(k, 8'h20, 1'b0, 1'b0, "level_high");
    exp_push(LAT + 10, 8'h00, 1'b0, 1'b0, "level_drop");
    IR = 8'h20;
    tick(10);
    IR = 8'h00;
    tick(LAT + 2);
    LTIM = 1'b0;
    tick(1);

    // Freeze during 4-cycle acknowledge while 0x81 arrives
    INTA = 1'b0; IR = 8'h81;
    for (int k = 1; k <= 4; k++) exp_push(k, 8'h00, 1'b1, 1'b1, "freeze_hold");
    exp_push(5, 8'h00, 1'b0, 1'b1, "freeze_release");
    exp_push(6, 8'h81, 1'b0, 1'b1, "freeze_catchup");
    tick(4);
    INTA = 1'b1;
    tick(3);

    // Clear wins over a fresh set on the same bit
    IR = 8'h80; clearFlag = 1'b1; clearBit = 3'd0;
    exp_push(1, 8'h80, 1'b0, 1'b1, "prep_clear_bit0");
    tick(1);
    clearFlag = 1'b0;
    tick(LAT + 1);
    IR = 8'h81;
    tick(LAT - 1);
    clearFlag = 1'b1; clearBit = 3'd0;
    exp_push(1, 8'h80, 1'b0, 1'b1, "clear_beats_set");
    tick(1);
    clearFlag = 1'b0;

    // ICW1 clears a full IRR; held-high lines need a low phase to re-set
    IR = 8'h00;
    tick(LAT + 1);
    IR = 8'hFF;
    exp_push(LAT, 8'hFF, 1'b0, 1'b1, "all_set");
    tick(LAT + 1);
    ICW1Write = 1'b1;
    exp_push(1, 8'h00, 1'b0, 1'b1, "icw1_clear");
    exp_push(4, 8'h00, 1'b0, 1'b1, "icw1_no_reset");
    tick(1);
    ICW1Write = 1'b0;
    tick(4);
    IR = 8'h00;
    tick(3);
    IR = 8'hFF;
    exp_push(LAT, 8'hFF, 1'b0, 1'b1, "icw1_rearm");
    tick(LAT + 1);

    // Reset in the middle of an acknowledge
    IR = 8'h00; ICW1Write = 1'b1;
    exp_push(1, 8'h00, 1'b0, 1'b1, "icw1_prep");
    tick(1);
    ICW1Write = 1'b0;
    tick(LAT + 1);
    IR = 8'h10;
    exp_push(LAT, 8'h10, 1'b0, 1'b1, "prep_irr10");
    tick(LAT + 1);
    INTA = 1'b0;
    exp_push(1, 8'h10, 1'b1, 1'b1, "ack_frozen");
    tick(2);
    rst_n = 1'b0;
    exp_push(1, 8'h00, 1'b0, 1'b1, "reset_mid_ack");
    tick(2);
    exp_push(1, 8'h00, 1'b0, 1'b1, "reset_mid_ack_hold");
    INTA = 1'b1; IR = 8'h00;
    tick(1);

    // First edge after reset release is caught
    rst_n = 1'b1; IR = 8'h08;
    exp_push(LAT - 1, 8'h00, 1'b0, 1'b1, "post_reset_before");
    exp_push(LAT,     8'h08, 1'b0, 1'b1, "post_reset_first_edge");
    tick(LAT + 1);

    // Single-cycle pulse on IR[3]
    IR = 8'h00;
    tick(LAT + 1);
    ICW1Write = 1'b1;
    exp_push(1, 8'h00, 1'b0, 1'b1, "pulse_prep");
    tick(1);
    ICW1Write = 1'b0;
    tick(2);
    IR = 8'h08;
`ifdef IRR_GLITCH_FILTER_EN
    for (int k = 1; k <= 8; k++) exp_push(k, 8'h00, 1'b0, 1'b1, "glitch_rejected");
`else
    exp_push(LAT,     8'h08, 1'b0, 1'b1, "pulse_captured");
    exp_push(LAT + 3, 8'h08, 1'b0, 1'b1, "pulse_latched");
`endif
    tick(1);
    IR = 8'h00;
    tick(10);

    // Drain the scoreboard; anything left was never reached
    tick(20);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d still pending at edge %0d",
               sb[0].nm, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_request_register.md
INTERRUPT_REQUEST_REGISTER -- requirements
Module: interrupt_request_register

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages synchronizing each IR input (legal 2..4).
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port IR  input  8  raw interrupt request lines IR0..IR7, asynchronous to clk, active-high.
REQ-005 Port LTIM  input  1  trigger mode: 1 = level-triggered, 0 = edge-triggered; quasi-static.
REQ-006 Port ICW1Write  input  1  one-cycle pulse; clears IRR and edge-arm state.
REQ-007 Port INTA  input  1  interrupt acknowledge, active-low, synchronous to clk.
REQ-008 Port clearFlag  input  1  acknowledge-clear request from priority resolver, active-high.
REQ-009 Port clearBit  input  3  index of the IRR bit to clear when clearFlag is high.
REQ-010 Port IRR  output  8  registered interrupt request register feeding the priority resolver.
REQ-011 Port IRRFrozen  output  1  high while IRR updates from IR are suspended.

Function
REQ-012 Each IR[n] SHALL pass through a SYNC_STAGES-deep synchronizer; the last stage is the synced value S[n].
REQ-013 Edge mode: an arm bit A[n] SHALL be set whenever S[n] = 0, and IRR[n] SHALL set on a clock where S[n] = 1 and A[n] = 1; setting IRR[n] clears A[n].
REQ-014 Edge mode: IR[n] held high SHALL NOT re-set IRR[n] after a clear until S[n] has been 0 for at least one clock.
REQ-015 Level mode: IRR[n] SHALL set on any clock with S[n] = 1 and SHALL clear on any clock with S[n] = 0, with A[n] ignored.
REQ-016 Latency: a 0->1 step on IR[n] that meets setup SHALL appear on IRR[n] at the (SYNC_STAGES+1)th rising clk edge, in both modes.
REQ-017 Freeze: IRRFrozen SHALL be high from the clock after INTA is sampled 0 until the clock after INTA is sampled 1.
REQ-018 While IRRFrozen = 1, IRR bits SHALL NOT set or clear from IR; A[n] keeps tracking S[n].
REQ-019 Acknowledge clear: on a clock with clearFlag = 1, IRR[clearBit] SHALL be 0 at the next edge, regardless of freeze or mode.
REQ-020 Clear versus set on the same bit in the same clock: the clear SHALL win.
REQ-021 Bits other than clearBit SHALL follow REQ-013..REQ-018 unaffected on the same clock.
REQ-022 ICW1Write = 1 SHALL clear all IRR bits and all A[n] at the next edge, with priority over set and clear.
REQ-023 Edges then re-arm only after S[n] is seen at 0.
REQ-024 An LTIM change SHALL take effect on the next clock; IRR contents are kept across the change.
REQ-025 Masking is not performed here; IRR reflects requests regardless of IMR.

Reset
REQ-026 While rst_n = 0, the block SHALL hold IRR = 8'h00, IRRFrozen = 0, all synchronizer stages = 0 and all A[n] = 0, independent of clk.
REQ-027 The first IR edge SHALL be detectable after release, since S = 0 arms every bit on the first clock.
REQ-028 Reset asserted mid-acknowledge SHALL abort the freeze; IRRFrozen = 0 after release.

Configuration
REQ-029 Macro IRR_GLITCH_FILTER_EN, when defined, SHALL add one filter register per line.
REQ-030 With the filter, S[n] changes only after two consecutive equal synchronizer outputs; this adds one clock to REQ-016 latency and rejects single-clock pulses.
REQ-031 Without IRR_GLITCH_FILTER_EN, S[n] is the raw synchronizer output with latency as in REQ-016.

Verification
REQ-032 Edge mode, SYNC_STAGES=2, IR=8'h04 at cycle 0 -> IRR=8'h04 at edge 3; held high, clearFlag=1, clearBit=2 -> IRR=8'h00 and stays 0 until IR[2] toggles 0->1.
REQ-033 Level mode, IR[5] pulsed high 10 cycles -> IRR[5] high for 10 cycles delayed by 3, then 0.
REQ-034 INTA=0 for 4 cycles while IR=8'h81 arrives -> IRR unchanged and IRRFrozen=1 during the pulse; IRR=8'h81 within 1 cycle after freeze ends.
REQ-035 Same cycle clearFlag=1, clearBit=0, with a fresh IR0 rising edge -> IRR[0]=0 (clear wins).
REQ-036 ICW1Write with IRR=8'hFF and IR held high, edge mode -> IRR=8'h00 with no re-set until lines go low, then high.
REQ-037 rst_n low mid-INTA with IRR=8'h10 -> IRR=8'h00, IRRFrozen=0 immediately; with IRR_GLITCH_FILTER_EN, a 1-cycle IR[3] pulse -> IRR[3] never set.
